batch_run_ctrl: RTL and testbench

Host-side run controller for the program-2 processor. Streams a 30-byte input block into data memory at Core[30..59], holds the core in reset while loading, releases it and pulses Start, waits for Ack (with a timeout), then reclaims the memory port and streams the 30 result bytes from Core[0..29]. It repeats this indefinitely, one block per run, replacing the hand-driven Reset/Start/preload sequence.

---
 rtl/batch_ctrl_pkg.sv | 20 ++
 rtl/run_timer.sv | 29 ++
 rtl/batch_run_ctrl.sv | 135 +++++++++++++
 tb/tb_batch_run_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/batch_ctrl_pkg.sv
// Shared constants and state encodings for the batch run controller.
package batch_ctrl_pkg;

  localparam int BLOCK_LEN_DEF = 30;
  localparam int IN_BASE_DEF   = 30;
  localparam int OUT_BASE_DEF  = 0;
  localparam int TIMEOUT_DEF   = 4096;

  typedef logic [1:0] state_t;

  localparam state_t ST_LOAD  = 2'd0;
  localparam state_t ST_START = 2'd1;
  localparam state_t ST_RUN   = 2'd2;
  localparam state_t ST_DRAIN = 2'd3;

  // Drain sub-phase: RD presents the address, VAL offers the byte.
  localparam logic PH_RD  = 1'b0;
  localparam logic PH_VAL = 1'b1;

endpackage

// File: rtl/run_timer.sv
// Up-counting run timer; tc flags the last permitted RUN cycle.
module run_timer #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] count;

  // Count RUN cycles from zero; cleared whenever the core is not running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == TW'(TIMEOUT - 1));

endmodule

// File: rtl/batch_run_ctrl.sv
// Host-side run controller: load a block, run the core, drain results, repeat.
//
//   state | meaning
//   LOAD  | core held in reset, input bytes written to Core[IN_BASE..]
//   START | one-cycle Start pulse, core owns memory
//   RUN   | waiting for CoreAck or the run timer terminal count
//   DRAIN | core held in reset, result bytes read from Core[OUT_BASE..]
module batch_run_ctrl
  import batch_ctrl_pkg::*;
#(
  parameter int BLOCK_LEN = BLOCK_LEN_DEF,
  parameter int IN_BASE   = IN_BASE_DEF,
  parameter int OUT_BASE  = OUT_BASE_DEF,
  parameter int ADDR_W    = 8,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              InValid,
  output logic              InReady,
  input  logic [7:0]        InData,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [7:0]        OutData,
  output logic              MemSel,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemWrEn,
  output logic [7:0]        MemWrData,
  input  logic [7:0]        MemRdData,
  output logic              CoreReset,
  output logic              CoreStart,
  input  logic              CoreAck,
  output logic              TimeoutFlag,
  output logic [15:0]       BlockCount
);

  localparam logic [4:0] IDX_LAST = 5'(BLOCK_LEN - 1);

  state_t      state;
  state_t      state_nx;
  logic        phase;
  logic [4:0]  idx;
  logic        in_ready_q;
  logic        val_fresh;
  logic [7:0]  out_data_q;
  logic        timeout_q;
  logic [15:0] block_cnt;
  logic        tc;
  logic        in_hs;
  logic        out_hs;
  logic        idx_last;

  assign in_hs    = (state == ST_LOAD) && InValid && in_ready_q;
  assign out_hs   = (state == ST_DRAIN) && (phase == PH_VAL) && OutReady;
  assign idx_last = (idx == IDX_LAST);

  run_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (Clk),
    .rst_n  (Reset),
    .clear  (state != ST_RUN),
    .enable (state == ST_RUN),
    .tc     (tc)
  );

  // Next-state selection; Ack takes priority over the timer.
  always_comb begin
    state_nx = state;
    case (state)
      ST_LOAD:  if (in_hs && idx_last) state_nx = ST_START;
      ST_START: state_nx = ST_RUN;
      ST_RUN:   if (CoreAck || tc) state_nx = ST_DRAIN;
      ST_DRAIN: if (out_hs && idx_last) state_nx = ST_LOAD;
      default:  state_nx = ST_LOAD;
    endcase
  end

  // State, byte index, drain sub-phase, sticky flag and block counter.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= ST_LOAD;
      phase      <= PH_RD;
      idx        <= '0;
      in_ready_q <= 1'b0;
      val_fresh  <= 1'b0;
      out_data_q <= '0;
      timeout_q  <= 1'b0;
      block_cnt  <= '0;
    end else begin
      state      <= state_nx;
      in_ready_q <= (state_nx == ST_LOAD);
      val_fresh  <= 1'b0;
      // Read data arrives during the first VAL cycle; latch it to hold it stable.
      if (val_fresh) out_data_q <= MemRdData;
      case (state)
        ST_LOAD: begin
          if (in_hs) idx <= idx_last ? 5'd0 : idx + 5'd1;
        end
        ST_RUN: begin
          phase <= PH_RD;
          if (!CoreAck && tc) timeout_q <= 1'b1;
        end
        ST_DRAIN: begin
          if (phase == PH_RD) begin
            phase     <= PH_VAL;
            val_fresh <= 1'b1;
          end else if (OutReady) begin
            phase <= PH_RD;
            if (idx_last) begin
              idx       <= '0;
              block_cnt <= block_cnt + 16'd1;
            end else begin
              idx <= idx + 5'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign InReady     = in_ready_q;
  assign OutValid    = (state == ST_DRAIN) && (phase == PH_VAL);
  assign OutData     = val_fresh ? MemRdData : out_data_q;
  assign MemSel      = (state == ST_LOAD) || (state == ST_DRAIN);
  assign CoreReset   = (state == ST_LOAD) || (state == ST_DRAIN);
  assign CoreStart   = (state == ST_START);
  assign MemWrEn     = in_hs;
  assign MemWrData   = in_hs ? InData : 8'h00;
  assign MemAddr     = in_hs               ? ADDR_W'(IN_BASE) + ADDR_W'(idx)  :
                       (state == ST_DRAIN) ? ADDR_W'(OUT_BASE) + ADDR_W'(idx) :
                                             '0;
  assign TimeoutFlag = timeout_q;
  assign BlockCount  = block_cnt;

endmodule

// File: tb/tb_batch_run_ctrl.sv
// Self-checking bench for batch_run_ctrl with a shared memory and core model.
module tb_batch_run_ctrl;

  localparam int TO   = 64;
  localparam int BL   = 30;
  localparam int INB  = 30;
  localparam int OUTB = 0;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [7:0]  InData = 8'h00;
  logic        OutValid;
  logic        OutReady = 1'b0;
  logic [7:0]  OutData;
  logic        MemSel;
  logic [7:0]  MemAddr;
  logic        MemWrEn;
  logic [7:0]  MemWrData;
  logic [7:0]  MemRdData;
  logic        CoreReset;
  logic        CoreStart;
  logic        CoreAck;
  logic        TimeoutFlag;
  logic [15:0] BlockCount;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic [7:0] rd_q = 8'h00;
  logic       core_ack = 1'b0;
  logic       core_run = 1'b0;
  int         core_cnt = 0;
  int         ack_at_cfg = 1000;
  int         exp_blocks = 0;
  logic       exp_tflag = 1'b0;

  batch_run_ctrl #(
    .BLOCK_LEN (BL),
    .IN_BASE   (INB),
    .OUT_BASE  (OUTB),
    .ADDR_W    (8),
    .TIMEOUT   (TO)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .InValid     (InValid),
    .InReady     (InReady),
    .InData      (InData),
    .OutValid    (OutValid),
    .OutReady    (OutReady),
    .OutData     (OutData),
    .MemSel      (MemSel),
    .MemAddr     (MemAddr),
    .MemWrEn     (MemWrEn),
    .MemWrData   (MemWrData),
    .MemRdData   (MemRdData),
    .CoreReset   (CoreReset),
    .CoreStart   (CoreStart),
    .CoreAck     (CoreAck),
    .TimeoutFlag (TimeoutFlag),
    .BlockCount  (BlockCount)
  );

  always #5 Clk = ~Clk;

  assign MemRdData = rd_q;
  assign CoreAck   = core_ack;

  // Memory with registered read, plus a core that copies Core[30+i]+1 into Core[i] when it acks.
  always @(posedge Clk) begin
    if (MemSel && MemWrEn) mem[MemAddr] <= MemWrData;
    if (MemSel) rd_q <= mem[MemAddr];
    if (CoreReset) begin
      core_ack <= 1'b0;
      core_run <= 1'b0;
      core_cnt <= 0;
    end else if (CoreStart) begin
      core_run <= 1'b1;
      core_cnt <= 0;
      if (ack_at_cfg == 0) begin
        core_ack <= 1'b1;
        for (int i = 0; i < BL; i++) mem[OUTB + i] <= mem[INB + i] + 8'd1;
      end
    end else if (core_run && !core_ack) begin
      core_cnt <= core_cnt + 1;
      if (core_cnt + 1 == ack_at_cfg) begin
        core_ack <= 1'b1;
        for (int i = 0; i < BL; i++) mem[OUTB + i] <= mem[INB + i] + 8'd1;
      end
    end
  end

  task automatic check_reset_values(input string name);
    logic [52:0] got_v;
    logic [52:0] exp_v;
    got_v = {InReady, OutValid, OutData, MemSel, MemWrEn, MemAddr, MemWrData,
             CoreReset, CoreStart, TimeoutFlag, BlockCount};
    exp_v = {1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0000};
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL %s reset_values: got %h expected %h", name, got_v, exp_v);
    end
  endtask

  task automatic apply_reset();
    @(negedge Clk);
    InValid = 1'b0;
    OutReady = 1'b0;
    #2 Reset = 1'b0;
    #1;
    check_reset_values("apply_reset");
    @(negedge Clk);
    Reset = 1'b1;
    exp_blocks = 0;
    exp_tflag = 1'b0;
  endtask

  // One full block: load random bytes, run, drain; compare against the memory-level model.
  task automatic run_block(input string name, input int ack_at, input int rmode);
    logic [7:0] din [BL];
    logic [7:0] got [$];
    int sent, cyc, start_cyc, drain_cyc, first_val, stab_err, msel_err, exp_run;
    logic hold;
    logic [7:0] hold_data;
    bit acked;
    for (int i = 0; i < BL; i++) din[i] = 8'($urandom);
    ack_at_cfg = ack_at;
    sent = 0; cyc = 0; start_cyc = -1; drain_cyc = -1; first_val = -1;
    stab_err = 0; msel_err = 0; hold = 1'b0; hold_data = 8'h00;
    while (got.size() < BL && cyc < 600) begin
      @(negedge Clk);
      InValid = (sent < BL) && ($urandom_range(0, 3) != 0);
      if (sent < BL) InData = din[sent];
      case (rmode)
        0:       OutReady = 1'b1;
        1:       OutReady = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: OutReady = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (MemSel && !CoreReset) msel_err++;
      if (CoreStart && start_cyc < 0) start_cyc = cyc;
      if (start_cyc >= 0 && drain_cyc < 0 && MemSel) drain_cyc = cyc;
      if (drain_cyc >= 0 && first_val < 0 && OutValid) first_val = cyc;
      if (hold && !(OutValid && OutData == hold_data)) stab_err++;
      hold = OutValid && !OutReady;
      hold_data = OutData;
      if (InValid && InReady) sent++;
      if (OutValid && OutReady) got.push_back(OutData);
      cyc++;
    end
    @(negedge Clk);
    InValid = 1'b0;
    OutReady = 1'b0;
    #1;

    acked = (ack_at < TO);
    for (int i = 0; i < BL; i++) ref_mem[INB + i] = din[i];
    if (acked) for (int i = 0; i < BL; i++) ref_mem[OUTB + i] = din[i] + 8'd1;
    else exp_tflag = 1'b1;
    exp_blocks++;
    exp_run = acked ? ack_at + 1 : TO;

    checks++;
    if (got.size() != BL) begin
      failures++;
      $display("FAIL %s byte_count: got %0d expected %0d (cycles %0d)", name, got.size(), BL, cyc);
    end
    for (int i = 0; i < BL && i < got.size(); i++) begin
      checks++;
      if (got[i] !== ref_mem[OUTB + i]) begin
        failures++;
        $display("FAIL %s out_byte[%0d]: got %h expected %h", name, i, got[i], ref_mem[OUTB + i]);
      end
    end
    checks++;
    if (start_cyc < 0 || drain_cyc - start_cyc - 1 != exp_run) begin
      failures++;
      $display("FAIL %s run_cycles: got %0d expected %0d", name, drain_cyc - start_cyc - 1, exp_run);
    end
    checks++;
    if (first_val - drain_cyc != 1) begin
      failures++;
      $display("FAIL %s drain_to_valid: got %0d expected 1", name, first_val - drain_cyc);
    end
    checks++;
    if (TimeoutFlag !== exp_tflag) begin
      failures++;
      $display("FAIL %s timeout_flag: got %b expected %b", name, TimeoutFlag, exp_tflag);
    end
    checks++;
    if (BlockCount !== 16'(exp_blocks)) begin
      failures++;
      $display("FAIL %s block_count: got %0d expected %0d", name, BlockCount, exp_blocks);
    end
    checks++;
    if (stab_err != 0) begin
      failures++;
      $display("FAIL %s out_stability: got %0d violations expected 0", name, stab_err);
    end
    checks++;
    if (msel_err != 0) begin
      failures++;
      $display("FAIL %s memsel_core_reset: got %0d violations expected 0", name, msel_err);
    end
  endtask

  task automatic test_reset();
    #2 Reset = 1'b0;
    #1;
    check_reset_values("test_reset");
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    checks++;
    if (InReady !== 1'b0) begin
      failures++;
      $display("FAIL test_reset in_ready_before_edge: got %b expected 0", InReady);
    end
    @(negedge Clk);
    checks++;
    if (InReady !== 1'b1) begin
      failures++;
      $display("FAIL test_reset in_ready_after_edge: got %b expected 1", InReady);
    end
  endtask

  task automatic test_basic();
    run_block("basic", 50, 0);
  endtask

  task automatic test_backpressure();
    run_block("backpressure", 50, 1);
  endtask

  task automatic test_ack_terminal();
    run_block("ack_terminal", TO - 1, 0);
  endtask

  task automatic test_timeout();
    run_block("timeout", 1000, 0);
  endtask

  task automatic test_mid_load_reset();
    int sent;
    int guard;
    sent = 0;
    guard = 0;
    while (sent < 12 && guard < 200) begin
      @(negedge Clk);
      InValid = 1'b1;
      InData = 8'($urandom);
      #1;
      if (InReady) sent++;
      guard++;
    end
    checks++;
    if (sent != 12) begin
      failures++;
      $display("FAIL mid_load_reset partial_load: got %0d expected 12", sent);
    end
    @(negedge Clk);
    #2 Reset = 1'b0;
    #1;
    check_reset_values("mid_load_reset");
    @(negedge Clk);
    InValid = 1'b0;
    Reset = 1'b1;
    exp_blocks = 0;
    exp_tflag = 1'b0;
    run_block("after_reset", 50, 0);
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int b = 0; b < 3; b++) run_block("back_to_back", int'($urandom_range(0, 40)), 2);
    checks++;
    if (BlockCount !== 16'd3) begin
      failures++;
      $display("FAIL back_to_back total_blocks: got %0d expected 3", BlockCount);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    test_reset();
    test_basic();
    test_backpressure();
    test_ack_terminal();
    test_timeout();
    test_mid_load_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
